// File: rtl/battle_turn_sequencer.sv
// battle_turn_sequencer
//   Runs one battle's turn sequence: loads starting HP for two 3-member teams
//   from the stats ROM, orders each turn's two attacks by speed, applies the
//   damage calculator's result with saturation, waits for a text-advance ack
//   after every hit, switches fainted members in, and reports win/lose.
//
// Ports
//   Clk, Reset              clock; synchronous active-high reset
//   start                   begin a battle (accepted in IDLE only)
//   player_team/enemy_team  packed species IDs, member i at [ID_W*i +: ID_W]
//   rom_addr / rom_hp       combinational stats ROM lookup used during INIT
//   move_go                 execute a turn (accepted in WAIT_MOVE only)
//   player_spd/enemy_spd    active member speeds, sampled on move_go
//   damage                  calculator result for the current attacker
//   ack                     battle text advanced (ACK1/ACK2/DONE only)
//   is_player               1 while the player is the attacker in HIT1/HIT2
//   busy                    high in every state except IDLE and DONE
//   cur_mon/opp_mon         active member indices
//   cur_hp/opp_hp           HP of the active members
//   done/result             battle over; result 1 = win, 0 = lose
module battle_turn_sequencer #(
  parameter int HP_W      = 8,
  parameter int ID_W      = 3,
  parameter int TEAM_SIZE = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [3*ID_W-1:0]   player_team,
  input  logic [3*ID_W-1:0]   enemy_team,
  output logic [ID_W-1:0]     rom_addr,
  input  logic [HP_W-1:0]     rom_hp,
  input  logic                move_go,
  input  logic [HP_W-1:0]     player_spd,
  input  logic [HP_W-1:0]     enemy_spd,
  input  logic [HP_W-1:0]     damage,
  input  logic                ack,
  output logic                is_player,
  output logic                busy,
  output logic [1:0]          cur_mon,
  output logic [1:0]          opp_mon,
  output logic [HP_W-1:0]     cur_hp,
  output logic [HP_W-1:0]     opp_hp,
  output logic                done,
  output logic                result
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_MOVE, S_HIT1, S_ACK1, S_HIT2, S_ACK2, S_SWITCH, S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_k;
  logic [HP_W-1:0] r_player_hp [TEAM_SIZE];
  logic [HP_W-1:0] r_enemy_hp  [TEAM_SIZE];
  logic [1:0]      r_cur_mon;
  logic [1:0]      r_opp_mon;
  logic            r_first_player;
  logic            r_result;

  logic [1:0]      w_load_idx;
  logic [HP_W-1:0] w_player_act_hp;
  logic [HP_W-1:0] w_enemy_act_hp;
  logic [HP_W-1:0] w_player_hit_hp;
  logic [HP_W-1:0] w_enemy_hit_hp;
  logic            w_player_wiped;
  logic            w_enemy_wiped;
  logic [1:0]      w_player_alive;
  logic [1:0]      w_enemy_alive;
  logic            w_player_attacks;
  logic            w_defender_enemy;
  logic            w_defender_wiped;

  // k = 0..2 loads player members, k = 3..5 loads enemy members.
  assign w_load_idx = (r_k < 3'd3) ? r_k[1:0] : 2'(r_k - 3'd3);

  assign w_player_act_hp = r_player_hp[r_cur_mon];
  assign w_enemy_act_hp  = r_enemy_hp[r_opp_mon];

  // Damage saturates at 0 rather than wrapping.
  assign w_player_hit_hp = (w_player_act_hp > damage) ? w_player_act_hp - damage : '0;
  assign w_enemy_hit_hp  = (w_enemy_act_hp  > damage) ? w_enemy_act_hp  - damage : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_player_wiped = 1'b1;
    w_enemy_wiped  = 1'b1;
    w_player_alive = r_cur_mon;
    w_enemy_alive  = r_opp_mon;
    // Scan downward so the lowest living index is the one that sticks.
    for (int i = TEAM_SIZE - 1; i >= 0; i--) begin
      if (r_player_hp[i] != '0) begin
        w_player_wiped = 1'b0;
        w_player_alive = 2'(i);
      end
      if (r_enemy_hp[i] != '0) begin
        w_enemy_wiped = 1'b0;
        w_enemy_alive = 2'(i);
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    if (r_state == S_INIT) begin
      if (r_k < 3'd3) rom_addr = player_team[ID_W*int'(w_load_idx) +: ID_W];
      else            rom_addr = enemy_team[ID_W*int'(w_load_idx) +: ID_W];
    end
  end

  // The first attacker strikes in HIT1, the other side in HIT2.
  assign w_player_attacks = ((r_state == S_HIT1) &&  r_first_player) ||
                            ((r_state == S_HIT2) && !r_first_player);
  assign w_defender_enemy = (r_state == S_ACK1) ? r_first_player : !r_first_player;
  assign w_defender_wiped = w_defender_enemy ? w_enemy_wiped : w_player_wiped;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_cur_mon      <= '0;
      r_opp_mon      <= '0;
      r_first_player <= 1'b0;
      r_result       <= 1'b0;
      // NOTE: the HP files are cleared on reset so a reset mid-battle leaves
      // cur_hp/opp_hp at 0 instead of exposing the stale battle's values.
      for (int i = 0; i < TEAM_SIZE; i++) begin
        r_player_hp[i] <= '0;
        r_enemy_hp[i]  <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k       <= '0;
            r_cur_mon <= '0;
            r_opp_mon <= '0;
            r_state   <= S_INIT;
          end
        end
        S_INIT: begin
          if (r_k < 3'd3) r_player_hp[w_load_idx] <= rom_hp;
          else            r_enemy_hp[w_load_idx]  <= rom_hp;
          r_k <= r_k + 3'd1;
          if (r_k == 3'd5) begin
            // Player HP is fully loaded by k=5; an all-zero team loses at once,
            // even if the enemy team is all zero as well.
            if (w_player_wiped) begin
              r_result <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_WAIT_MOVE;
            end
          end
        end
        S_WAIT_MOVE: begin
          if (move_go) begin
            r_first_player <= (player_spd >= enemy_spd);
            r_state        <= S_HIT1;
          end
        end
        S_HIT1, S_HIT2: begin
          // A fainted attacker forfeits its hit.
          if (w_player_attacks) begin
            if (w_player_act_hp != '0) r_enemy_hp[r_opp_mon] <= w_enemy_hit_hp;
          end else begin
            if (w_enemy_act_hp != '0) r_player_hp[r_cur_mon] <= w_player_hit_hp;
          end
          r_state <= (r_state == S_HIT1) ? S_ACK1 : S_ACK2;
        end
        S_ACK1, S_ACK2: begin
          if (ack) begin
            if (w_defender_wiped) begin
              r_result <= w_defender_enemy;
              r_state  <= S_DONE;
            end else begin
              r_state  <= (r_state == S_ACK1) ? S_HIT2 : S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          if (w_player_act_hp == '0) r_cur_mon <= w_player_alive;
          if (w_enemy_act_hp  == '0) r_opp_mon <= w_enemy_alive;
          r_state <= S_WAIT_MOVE;
        end
        S_DONE: begin
          if (ack) begin
            r_result <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign is_player = w_player_attacks;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign cur_mon   = r_cur_mon;
  assign opp_mon   = r_opp_mon;
  assign cur_hp    = w_player_act_hp;
  assign opp_hp    = w_enemy_act_hp;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// tb_battle_turn_sequencer
//   Scoreboard bench for battle_turn_sequencer. Stimulus pushes hand-computed
//   output snapshots tagged with the cycle they apply to; a monitor pops and
//   compares them on the falling edge. A second queue holds the expected
//   battle result, compared whenever the DUT raises done.
module tb_battle_turn_sequencer;

  localparam int HP_W = 8;
  localparam int ID_W = 3;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              start;
  logic [3*ID_W-1:0] player_team;
  logic [3*ID_W-1:0] enemy_team;
  logic [ID_W-1:0]   rom_addr;
  logic [HP_W-1:0]   rom_hp;
  logic              move_go;
  logic [HP_W-1:0]   player_spd;
  logic [HP_W-1:0]   enemy_spd;
  logic [HP_W-1:0]   damage;
  logic              ack;
  logic              is_player;
  logic              busy;
  logic [1:0]        cur_mon;
  logic [1:0]        opp_mon;
  logic [HP_W-1:0]   cur_hp;
  logic [HP_W-1:0]   opp_hp;
  logic              done;
  logic              result;

  logic [HP_W-1:0]   rom_tab [8];
  assign rom_hp = rom_tab[rom_addr];

  battle_turn_sequencer #(.HP_W(HP_W), .ID_W(ID_W), .TEAM_SIZE(3)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .player_team(player_team), .enemy_team(enemy_team),
    .rom_addr(rom_addr), .rom_hp(rom_hp),
    .move_go(move_go), .player_spd(player_spd), .enemy_spd(enemy_spd),
    .damage(damage), .ack(ack), .is_player(is_player), .busy(busy),
    .cur_mon(cur_mon), .opp_mon(opp_mon), .cur_hp(cur_hp), .opp_hp(opp_hp),
    .done(done), .result(result)
  );

  always #5 Clk = ~Clk;

  // Snapshot layout: {rom_addr, is_player, busy, cur_mon, opp_mon, cur_hp, opp_hp, done, result}
  function automatic logic [26:0] pk(input logic [2:0] ra, input logic ip, input logic bsy,
                                     input logic [1:0] cm, input logic [1:0] om,
                                     input logic [7:0] ch, input logic [7:0] oh,
                                     input logic dn, input logic rs);
    return {ra, ip, bsy, cm, om, ch, oh, dn, rs};
  endfunction

  // Snapshot of a mid-battle state with rom_addr 0 and done/result low.
  function automatic logic [26:0] st(input logic ip, input logic [1:0] cm, input logic [1:0] om,
                                     input logic [7:0] ch, input logic [7:0] oh);
    return pk(3'd0, ip, 1'b1, cm, om, ch, oh, 1'b0, 1'b0);
  endfunction

  localparam logic [26:0] M_ALL  = '1;
  localparam logic [26:0] M_CTRL = {3'h7, 1'b1, 1'b1, 2'b0, 2'b0, 8'h0, 8'h0, 1'b1, 1'b0};
  localparam logic [26:0] M_CTRR = {3'h7, 1'b1, 1'b1, 2'b0, 2'b0, 8'h0, 8'h0, 1'b1, 1'b1};

  typedef struct {
    int          cyc;
    string       name;
    logic [26:0] v;
    logic [26:0] m;
  } exp_t;

  exp_t exp_q[$];
  logic res_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_done = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic push(input int d, input string name, input logic [26:0] v,
                      input logic [26:0] m = M_ALL);
    exp_t e;
    e.cyc = cyc + d; e.name = name; e.v = v; e.m = m;
    exp_q.push_back(e);
  endtask

  // Monitor: snapshot comparisons plus a result check on every rising done.
  always @(negedge Clk) begin
    logic [26:0] act;
    exp_t        e;
    logic        r;
    act = pk(rom_addr, is_player, busy, cur_mon, opp_mon, cur_hp, opp_hp, done, result);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || ((act ^ e.v) & e.m) != '0) begin
        n_bad++;
        $display("FAIL %s: got %h want %h (mask %h) at cycle %0d, due %0d",
                 e.name, act & e.m, e.v & e.m, e.m, cyc, e.cyc);
      end
    end
    if (done && !prev_done) begin
      n_cmp++;
      if (res_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: done rose with result %0b, none expected", result);
      end else begin
        r = res_q.pop_front();
        if (result !== r) begin
          n_bad++;
          $display("FAIL battle_result: got %0b want %0b", result, r);
        end
      end
    end
    prev_done <= done;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start pulse; returns in WAIT_MOVE (or DONE) 7 cycles later.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    run(6);
  endtask

  // One turn from WAIT_MOVE at cycle m: HIT1 m+1, ACK1 m+2, HIT2 m+3,
  // ACK2 m+4, SWITCH m+5, WAIT_MOVE m+6. move_go is raised alongside the
  // first ack to show that ACK1 ignores it.
  task automatic do_turn(input logic [7:0] ps, input logic [7:0] es,
                         input logic [7:0] d1, input logic [7:0] d2);
    player_spd = ps; enemy_spd = es; damage = d1; move_go = 1'b1;
    tick();
    move_go = 1'b0;
    tick();
    ack = 1'b1; move_go = 1'b1; damage = d2;
    tick();
    ack = 1'b0; move_go = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  initial begin
    repeat (20000) @(posedge Clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; start = 1'b0; move_go = 1'b0; ack = 1'b0;
    player_spd = '0; enemy_spd = '0; damage = '0;
    player_team = {3'd2, 3'd1, 3'd0};
    enemy_team  = {3'd5, 3'd4, 3'd3};
    for (int i = 0; i < 8; i++) rom_tab[i] = 8'(20 + i);
    run(3);
    push(0, "reset_state", '0);
    tick();
    Reset = 1'b0;
    tick();

    // Initial load: rom_addr walks 0..5, then WAIT_MOVE with 20 / 23.
    push(1, "init_k0", pk(3'd0, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0,  8'd0,  1'b0, 1'b0));
    push(2, "init_k1", pk(3'd1, 1'b0, 1'b1, 2'd0, 2'd0, 8'd20, 8'd0,  1'b0, 1'b0));
    push(3, "init_k2", pk(3'd2, 1'b0, 1'b1, 2'd0, 2'd0, 8'd20, 8'd0,  1'b0, 1'b0));
    push(4, "init_k3", pk(3'd3, 1'b0, 1'b1, 2'd0, 2'd0, 8'd20, 8'd0,  1'b0, 1'b0));
    push(5, "init_k4", pk(3'd4, 1'b0, 1'b1, 2'd0, 2'd0, 8'd20, 8'd23, 1'b0, 1'b0));
    push(6, "init_k5", pk(3'd5, 1'b0, 1'b1, 2'd0, 2'd0, 8'd20, 8'd23, 1'b0, 1'b0));
    push(7, "init_wait", st(1'b0, 2'd0, 2'd0, 8'd20, 8'd23));
    do_start();

    // Player faster 50/40, damage 5 both ways.
    push(1, "spd_hit1",   st(1'b1, 2'd0, 2'd0, 8'd20, 8'd23));
    push(2, "spd_ack1",   st(1'b0, 2'd0, 2'd0, 8'd20, 8'd18));
    push(3, "spd_hit2",   st(1'b0, 2'd0, 2'd0, 8'd20, 8'd18));
    push(4, "spd_ack2",   st(1'b0, 2'd0, 2'd0, 8'd15, 8'd18));
    push(5, "spd_switch", st(1'b0, 2'd0, 2'd0, 8'd15, 8'd18));
    push(6, "spd_wait",   st(1'b0, 2'd0, 2'd0, 8'd15, 8'd18));
    do_turn(8'd50, 8'd40, 8'd5, 8'd5);

    // Speed tie 40/40: player still strikes first.
    push(1, "tie_hit1", st(1'b1, 2'd0, 2'd0, 8'd15, 8'd18));
    push(2, "tie_ack1", st(1'b0, 2'd0, 2'd0, 8'd15, 8'd13));
    push(3, "tie_hit2", st(1'b0, 2'd0, 2'd0, 8'd15, 8'd13));
    push(6, "tie_wait", st(1'b0, 2'd0, 2'd0, 8'd10, 8'd13));
    do_turn(8'd40, 8'd40, 8'd5, 8'd5);

    // Bring the enemy to 3 HP.
    push(2, "t3_ack1", st(1'b0, 2'd0, 2'd0, 8'd10, 8'd3));
    push(6, "t3_wait", st(1'b0, 2'd0, 2'd0, 8'd9,  8'd3));
    do_turn(8'd50, 8'd40, 8'd10, 8'd1);

    // Saturation 3-10 -> 0, fainted enemy skips its hit, switch to member 1.
    push(1, "sat_hit1",   st(1'b1, 2'd0, 2'd0, 8'd9, 8'd3));
    push(2, "sat_ack1",   st(1'b0, 2'd0, 2'd0, 8'd9, 8'd0));
    push(4, "skip_ack2",  st(1'b0, 2'd0, 2'd0, 8'd9, 8'd0));
    push(5, "sat_switch", st(1'b0, 2'd0, 2'd0, 8'd9, 8'd0));
    push(6, "sat_wait",   st(1'b0, 2'd0, 2'd1, 8'd9, 8'd24));
    do_turn(8'd50, 8'd40, 8'd10, 8'd50);

    // Reset asserted in ACK1 returns everything to 0.
    player_spd = 8'd50; enemy_spd = 8'd40; damage = 8'd1; move_go = 1'b1;
    push(1, "rst_hit1", st(1'b1, 2'd0, 2'd1, 8'd9, 8'd24));
    push(2, "rst_ack1", st(1'b0, 2'd0, 2'd1, 8'd9, 8'd23));
    push(3, "rst_mid",  '0);
    tick();
    move_go = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();

    // Win battle: enemy HP {0,0,4}, HP reloaded from the ROM.
    for (int i = 0; i < 3; i++) rom_tab[i] = 8'd30;
    rom_tab[3] = 8'd0; rom_tab[4] = 8'd0; rom_tab[5] = 8'd4;
    push(7, "win_reload", st(1'b0, 2'd0, 2'd0, 8'd30, 8'd0));
    do_start();
    push(3, "win_hit2_skip", st(1'b0, 2'd0, 2'd0, 8'd30, 8'd0));
    push(6, "win_switch_om2", st(1'b0, 2'd0, 2'd2, 8'd30, 8'd4));
    do_turn(8'd50, 8'd40, 8'd9, 8'd9);
    res_q.push_back(1'b1);
    push(1, "win_hit1",  st(1'b1, 2'd0, 2'd2, 8'd30, 8'd4));
    push(2, "win_ack1",  st(1'b0, 2'd0, 2'd2, 8'd30, 8'd0));
    push(3, "win_done",  pk(3'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd30, 8'd0, 1'b1, 1'b1));
    push(4, "win_hold",  pk(3'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd30, 8'd0, 1'b1, 1'b1));
    push(5, "win_idle",  '0, M_CTRL);
    do_turn(8'd50, 8'd40, 8'd4, 8'd4);

    // Lose battle: player HP {0,0,1}, enemy faster.
    rom_tab[0] = 8'd0; rom_tab[1] = 8'd0; rom_tab[2] = 8'd1;
    for (int i = 3; i < 6; i++) rom_tab[i] = 8'd50;
    push(7, "lose_reload", st(1'b0, 2'd0, 2'd0, 8'd0, 8'd50));
    do_start();
    push(1, "lose_hit1_enemy", st(1'b0, 2'd0, 2'd0, 8'd0, 8'd50));
    push(3, "lose_hit2_player", st(1'b1, 2'd0, 2'd0, 8'd0, 8'd50));
    push(6, "lose_switch_cm2", st(1'b0, 2'd2, 2'd0, 8'd1, 8'd50));
    do_turn(8'd10, 8'd40, 8'd9, 8'd9);
    res_q.push_back(1'b0);
    push(2, "lose_ack1", st(1'b0, 2'd2, 2'd0, 8'd0, 8'd50));
    push(3, "lose_done", pk(3'd0, 1'b0, 1'b0, 2'd2, 2'd0, 8'd0, 8'd50, 1'b1, 1'b0));
    push(5, "lose_idle", '0, M_CTRL);
    do_turn(8'd10, 8'd40, 8'd9, 8'd9);

    // Both teams load as all zero: immediate loss straight out of INIT.
    for (int i = 0; i < 6; i++) rom_tab[i] = 8'd0;
    res_q.push_back(1'b0);
    push(7, "init_wipe_done", pk(3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b0), M_CTRR);
    do_start();
    ack = 1'b1;
    push(1, "init_wipe_idle", '0, M_CTRL);
    tick();
    ack = 1'b0;
    run(3);

    n_cmp++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d snapshots / %0d results pending want 0 / 0",
               exp_q.size(), res_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/battle_turn_sequencer.md
Name: battle_turn_sequencer

Overview:
- Controls one battle's turn sequence for the battle FSM.
- Owns the HP register files for both 3-member teams and loads starting HP from the stats ROM.
- Each turn, orders the two attacks by speed, drives is_player to the damage calculator, and applies the returned damage.
- Waits for a text-advance ack after every hit, auto-switches fainted members, and reports win/lose.

Parameters:
HP_W, 8, width of HP and damage values
ID_W, 3, species ID width (stats ROM address)
TEAM_SIZE, 3, members per team (fixed at 3; indices are 2 bits)

Ports:
Clk  in  1  clock
Reset  in  1  reset; Reset, synchronous, active-high
start  in  1  single-cycle pulse that begins a battle; ignored unless in IDLE
player_team  in  3*ID_W  player species IDs, member i at bits [3i+2:3i]
enemy_team  in  3*ID_W  enemy species IDs, same packing
rom_addr  out  ID_W  stats ROM address (ROM is combinational)
rom_hp  in  HP_W  base HP returned for rom_addr in the same cycle
move_go  in  1  pulse: both moves chosen, execute a turn; ignored outside WAIT_MOVE
player_spd  in  HP_W  active player member speed
enemy_spd  in  HP_W  active enemy member speed
damage  in  HP_W  calculator result for the current is_player
ack  in  1  pulse: battle text advanced
is_player  out  1  1 = player is attacking this hit
busy  out  1  high in every state except IDLE and DONE
cur_mon  out  2  active player member index
opp_mon  out  2  active enemy member index
cur_hp  out  HP_W  HP of the active player member
opp_hp  out  HP_W  HP of the active enemy member
done  out  1  high while in DONE
result  out  1  valid when done: 1 = win, 0 = lose

Behaviour:
- Reset: from any state, including mid-turn, goes to IDLE and clears all HP registers, indices and counters to 0. Every output is 0; rom_addr is 0.
- States: IDLE, INIT, WAIT_MOVE, HIT1, ACK1, HIT2, ACK2, SWITCH, DONE.
- IDLE: on start, go to INIT with load counter k=0 and cur_mon=opp_mon=0.
- INIT: lasts 6 cycles, one per k = 0..5.
  - k<3: rom_addr = player_team[k]; player_hp[k] <= rom_hp.
  - k>=3: rom_addr = enemy_team[k-3]; enemy_hp[k-3] <= rom_hp.
  - After k=5, go to WAIT_MOVE.
  - An HP of 0 loaded from the ROM is legal; that member counts as fainted.
- WAIT_MOVE: on move_go, latch first = (player_spd >= enemy_spd) ? player : enemy. A tie goes to the player. Go to HIT1.
- HIT1 (1 cycle):
  - is_player = (first == player); damage is sampled in this same cycle.
  - If the attacker's active HP is > 0: defender HP <= (HP > damage) ? HP - damage : 0. Saturate at 0; no wrap.
  - If the attacker's active HP is 0, skip the hit (no HP change).
  - Go to ACK1.
- ACK1: on ack, if every member of the defending team has HP 0, go to DONE (result = defender is enemy). Otherwise go to HIT2.
- HIT2 / ACK2: as HIT1 / ACK1 with the roles swapped. ACK2 goes to SWITCH when neither team is wiped out.
- SWITCH (1 cycle):
  - If player_hp[cur_mon] == 0, cur_mon <= lowest index with HP > 0.
  - Likewise for opp_mon.
  - Both may switch in the same cycle.
  - Go to WAIT_MOVE.
- DONE: done=1 and result held. On ack, go to IDLE.
- Continuous outputs: cur_hp = player_hp[cur_mon]; opp_hp = enemy_hp[opp_mon]. is_player = 0 outside HIT1/HIT2.
- Ignored inputs:
  - ack outside ACK1/ACK2/DONE.
  - start outside IDLE.
  - move_go and ack asserted together are each handled only by the state that accepts them.
- Edge case: if the player team is wiped out during INIT (all player HP loaded as 0), go to DONE with result=0 after INIT instead of WAIT_MOVE. If both teams are all 0, the player-lose check takes precedence.
- Latency: start to WAIT_MOVE is 7 cycles. move_go to the first HP update is 1 cycle; the update is visible on cur_hp/opp_hp 2 cycles after move_go.

Test Plan:
- Init: player_team={0,1,2}, enemy_team={3,4,5}, ROM hp = 20+id. Pulse start → 6 cycles of rom_addr 0,1,2,3,4,5; at WAIT_MOVE, cur_hp=20, opp_hp=23, busy=1.
- Speed order: player_spd=50, enemy_spd=40, damage=5. After move_go, HIT1 has is_player=1 and opp_hp 23→18; after ack, HIT2 has is_player=0 and cur_hp 20→15. Tie 40/40 → player still attacks first.
- Saturation: opp_hp=3, damage=10 → opp_hp=0. Enemy second hit is skipped (cur_hp unchanged); SWITCH sets opp_mon=1 and opp_hp=24.
- Win: enemy HP {0,0,4}, opp_mon=2, player first, damage=4 → after ack in ACK1, done=1, result=1, no HIT2. Then ack → IDLE, done=0.
- Lose: player HP {0,0,1}, enemy faster, damage=9 → done=1, result=0.
- Reset mid-turn: assert Reset in ACK1 → next cycle IDLE with all outputs 0. A later start reloads all HP from the ROM.
